// File: rtl/pcie_rq_mux.sv
// pcie_rq_mux: packet-atomic round-robin merge of the NVMe read-request and
// write engines into one RQ stream, registered through a 2-entry skid buffer.
module pcie_rq_mux #(
  parameter int C_DATA_WIDTH        = 128,
  parameter int AXI4_RQ_TUSER_WIDTH = 62,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                           user_clk,
  input  logic                           user_reset_n,
  input  logic                           user_lnk_up,

  input  logic [C_DATA_WIDTH-1:0]        s0_rq_tdata,
  input  logic [AXI4_RQ_TUSER_WIDTH-1:0] s0_rq_tuser,
  input  logic [KEEP_WIDTH-1:0]          s0_rq_tkeep,
  input  logic                           s0_rq_tlast,
  input  logic                           s0_rq_tvalid,
  output logic                           s0_rq_tready,

  input  logic [C_DATA_WIDTH-1:0]        s1_rq_tdata,
  input  logic [AXI4_RQ_TUSER_WIDTH-1:0] s1_rq_tuser,
  input  logic [KEEP_WIDTH-1:0]          s1_rq_tkeep,
  input  logic                           s1_rq_tlast,
  input  logic                           s1_rq_tvalid,
  output logic                           s1_rq_tready,

  output logic [C_DATA_WIDTH-1:0]        m_rq_tdata,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] m_rq_tuser,
  output logic [KEEP_WIDTH-1:0]          m_rq_tkeep,
  output logic                           m_rq_tlast,
  output logic                           m_rq_tvalid,
  input  logic [3:0]                     m_rq_tready,

  output logic [CNT_WIDTH-1:0]           pkt_cnt0,
  output logic [CNT_WIDTH-1:0]           pkt_cnt1
);

  localparam int BEAT_W = C_DATA_WIDTH + AXI4_RQ_TUSER_WIDTH + KEEP_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t               state;
  logic                 rr_ptr;
  logic [BEAT_W-1:0]    head_beat;
  logic [BEAT_W-1:0]    skid_beat;
  logic [BEAT_W-1:0]    in_beat;
  logic                 head_valid;
  logic                 skid_valid;
  logic [CNT_WIDTH-1:0] cnt0_q;
  logic [CNT_WIDTH-1:0] cnt1_q;
  logic                 acc0;
  logic                 acc1;
  logic                 acc0_last;
  logic                 acc1_last;
  logic                 push;
  logic                 pop;
  logic                 unused_ready;

  // The skid entry is only ever occupied behind the head entry, so "full" is
  // just skid_valid; ready never sees m_rq_tready combinationally.
  assign s0_rq_tready = (state == GNT0) && !skid_valid;
  assign s1_rq_tready = (state == GNT1) && !skid_valid;

  assign acc0      = s0_rq_tvalid && s0_rq_tready;
  assign acc1      = s1_rq_tvalid && s1_rq_tready;
  assign acc0_last = acc0 && s0_rq_tlast;
  assign acc1_last = acc1 && s1_rq_tlast;
  assign push      = acc0 || acc1;
  assign pop       = head_valid && m_rq_tready[0];

  assign in_beat = (state == GNT1) ?
                   {s1_rq_tdata, s1_rq_tuser, s1_rq_tkeep, s1_rq_tlast} :
                   {s0_rq_tdata, s0_rq_tuser, s0_rq_tkeep, s0_rq_tlast};

  assign {m_rq_tdata, m_rq_tuser, m_rq_tkeep, m_rq_tlast} = head_beat;
  assign m_rq_tvalid = head_valid;
  assign pkt_cnt0    = cnt0_q;
  assign pkt_cnt1    = cnt1_q;

  assign unused_ready = ^m_rq_tready[3:1];

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (user_lnk_up) begin
            if (s0_rq_tvalid && (!s1_rq_tvalid || !rr_ptr)) begin
              state <= GNT0;
            end else if (s1_rq_tvalid) begin
              state <= GNT1;
            end
          end
        end
        GNT0: begin
          if (acc0_last) begin
            state  <= IDLE;
            rr_ptr <= 1'b1;
          end
        end
        GNT1: begin
          if (acc1_last) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Head register drives m_rq_*; the skid register catches the one beat that
  // can arrive after the sink stalls, before ready drops.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      head_beat  <= '0;
      skid_beat  <= '0;
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!head_valid) begin
            head_beat  <= in_beat;
            head_valid <= 1'b1;
          end else begin
            skid_beat  <= in_beat;
            skid_valid <= 1'b1;
          end
        end
        2'b01: begin
          if (skid_valid) begin
            head_beat  <= skid_beat;
            skid_valid <= 1'b0;
          end else begin
            head_valid <= 1'b0;
          end
        end
        2'b11: begin
          if (skid_valid) begin
            head_beat <= skid_beat;
            skid_beat <= in_beat;
          end else begin
            head_beat <= in_beat;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (acc0_last) begin
        cnt0_q <= cnt0_q + 1'b1;
      end
      if (acc1_last) begin
        cnt1_q <= cnt1_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcie_rq_mux.sv
// tb_pcie_rq_mux: directed and randomized checks of pcie_rq_mux against an
// acceptance-order scoreboard with per-source TLP counters.
module tb_pcie_rq_mux;

  localparam int DW = 128;
  localparam int UW = 62;
  localparam int KW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic          last;
    int            cyc;
  } beat_t;

  logic          user_clk;
  logic          user_reset_n;
  logic          user_lnk_up;
  logic [DW-1:0] s0_rq_tdata;
  logic [UW-1:0] s0_rq_tuser;
  logic [KW-1:0] s0_rq_tkeep;
  logic          s0_rq_tlast;
  logic          s0_rq_tvalid;
  logic          s0_rq_tready;
  logic [DW-1:0] s1_rq_tdata;
  logic [UW-1:0] s1_rq_tuser;
  logic [KW-1:0] s1_rq_tkeep;
  logic          s1_rq_tlast;
  logic          s1_rq_tvalid;
  logic          s1_rq_tready;
  logic [DW-1:0] m_rq_tdata;
  logic [UW-1:0] m_rq_tuser;
  logic [KW-1:0] m_rq_tkeep;
  logic          m_rq_tlast;
  logic          m_rq_tvalid;
  logic [3:0]    m_rq_tready;
  logic [15:0]   pkt_cnt0;
  logic [15:0]   pkt_cnt1;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  beat_t exp_q[$];
  beat_t out_log[$];
  logic [15:0] cnt_m0 = 0;
  logic [15:0] cnt_m1 = 0;
  int    owner = -1;
  bit    last_prev = 0;
  bit    preload0 = 0;

  pcie_rq_mux dut (
    .user_clk     (user_clk),
    .user_reset_n (user_reset_n),
    .user_lnk_up  (user_lnk_up),
    .s0_rq_tdata  (s0_rq_tdata),
    .s0_rq_tuser  (s0_rq_tuser),
    .s0_rq_tkeep  (s0_rq_tkeep),
    .s0_rq_tlast  (s0_rq_tlast),
    .s0_rq_tvalid (s0_rq_tvalid),
    .s0_rq_tready (s0_rq_tready),
    .s1_rq_tdata  (s1_rq_tdata),
    .s1_rq_tuser  (s1_rq_tuser),
    .s1_rq_tkeep  (s1_rq_tkeep),
    .s1_rq_tlast  (s1_rq_tlast),
    .s1_rq_tvalid (s1_rq_tvalid),
    .s1_rq_tready (s1_rq_tready),
    .m_rq_tdata   (m_rq_tdata),
    .m_rq_tuser   (m_rq_tuser),
    .m_rq_tkeep   (m_rq_tkeep),
    .m_rq_tlast   (m_rq_tlast),
    .m_rq_tvalid  (m_rq_tvalid),
    .m_rq_tready  (m_rq_tready),
    .pkt_cnt0     (pkt_cnt0),
    .pkt_cnt1     (pkt_cnt1)
  );

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_src(input int src, input logic valid, input logic [31:0] tag, input int beat,
                         input logic last);
    logic [DW-1:0] d = {tag, 32'(beat), $urandom(), $urandom()};
    logic [UW-1:0] u = UW'({$urandom(), $urandom()});
    logic [KW-1:0] k = KW'($urandom());
    if (src == 0) begin
      s0_rq_tvalid = valid;
      s0_rq_tdata  = d;
      s0_rq_tuser  = u;
      s0_rq_tkeep  = k;
      s0_rq_tlast  = last;
    end else begin
      s1_rq_tvalid = valid;
      s1_rq_tdata  = d;
      s1_rq_tuser  = u;
      s1_rq_tkeep  = k;
      s1_rq_tlast  = last;
    end
  endtask

  // Sends one TLP; called at posedge+1, returns at posedge+1 after the last beat is taken.
  task automatic apply_stimulus(input int src, input int nbeats, input logic [31:0] tag, input int max_gap);
    for (int b = 0; b < nbeats; b++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      bit acc = 1'b0;
      int waited = 0;
      if (gap > 0) begin
        set_src(src, 1'b0, tag, b, 1'b0);
        repeat (gap) begin
          @(posedge user_clk);
          #1;
        end
      end
      set_src(src, 1'b1, tag, b, (b == nbeats - 1));
      while (!acc) begin
        @(negedge user_clk);
        acc = (src == 0) ? s0_rq_tready : s1_rq_tready;
        @(posedge user_clk);
        #1;
        waited++;
        if (!acc && waited > 200) begin
          check_output("src_accept_timeout", 256'(src), 256'(99));
          set_src(src, 1'b0, tag, b, 1'b0);
          return;
        end
      end
    end
    set_src(src, 1'b0, tag, 0, 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge user_clk);
      n++;
    end while (m_rq_tvalid && n < 300);
    check_output("drain_timeout", 256'(m_rq_tvalid), 256'(0));
    @(posedge user_clk);
    #1;
  endtask

  task automatic do_reset();
    user_reset_n = 1'b0;
    set_src(0, 1'b0, 0, 0, 1'b0);
    set_src(1, 1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge user_clk);
    #1;
    user_reset_n = 1'b1;
    @(posedge user_clk);
    #1;
  endtask

  // Scoreboard: every accepted beat is queued in acceptance order; the output
  // must replay that queue exactly, and its length is the buffer occupancy.
  task automatic monitor();
    forever begin
      beat_t nb;
      @(negedge user_clk);
      cyc++;
      if (!user_reset_n) begin
        exp_q.delete();
        cnt_m0    = 0;
        cnt_m1    = 0;
        owner     = -1;
        last_prev = 1'b0;
      end else begin
        if (preload0) cnt_m0 = 16'hFFFF;
        check_output("m_tvalid", 256'(m_rq_tvalid), 256'(exp_q.size() != 0));
        if (m_rq_tvalid && exp_q.size() != 0) begin
          check_output("m_beat", 256'({m_rq_tdata, m_rq_tuser, m_rq_tkeep, m_rq_tlast}),
                       256'({exp_q[0].data, exp_q[0].user, exp_q[0].keep, exp_q[0].last}));
        end
        check_output("pkt_cnt0", 256'(pkt_cnt0), 256'(cnt_m0));
        check_output("pkt_cnt1", 256'(pkt_cnt1), 256'(cnt_m1));
        check_output("ready_excl", 256'(s0_rq_tready & s1_rq_tready), 256'(0));
        if (exp_q.size() >= 2) check_output("ready_full", 256'(s0_rq_tready | s1_rq_tready), 256'(0));
        if (last_prev) check_output("ready_gap", 256'(s0_rq_tready | s1_rq_tready), 256'(0));
        if (owner == 0) check_output("interleave0", 256'(s1_rq_tready), 256'(0));
        if (owner == 1) check_output("interleave1", 256'(s0_rq_tready), 256'(0));
        last_prev = 1'b0;
        if (m_rq_tvalid && m_rq_tready[0] && exp_q.size() != 0) begin
          nb     = exp_q.pop_front();
          nb.cyc = cyc;
          out_log.push_back(nb);
        end
        if (s0_rq_tvalid && s0_rq_tready) begin
          exp_q.push_back('{s0_rq_tdata, s0_rq_tuser, s0_rq_tkeep, s0_rq_tlast, cyc});
          owner = s0_rq_tlast ? -1 : 0;
          if (s0_rq_tlast) begin
            cnt_m0++;
            last_prev = 1'b1;
          end
        end
        if (s1_rq_tvalid && s1_rq_tready) begin
          exp_q.push_back('{s1_rq_tdata, s1_rq_tuser, s1_rq_tkeep, s1_rq_tlast, cyc});
          owner = s1_rq_tlast ? -1 : 1;
          if (s1_rq_tlast) begin
            cnt_m1++;
            last_prev = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_tlp(input string name, input int base, input logic [31:0] tag, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      check_output({name, "_tag"}, 256'(out_log[base+i].data[127:96]), 256'(tag));
      check_output({name, "_beat"}, 256'(out_log[base+i].data[95:64]), 256'(i));
      check_output({name, "_last"}, 256'(out_log[base+i].last), 256'(i == nbeats - 1));
    end
  endtask

  initial begin
    int base;
    int c0;
    bit done;
    logic [31:0] order_tags [4];

    user_reset_n = 1'b0;
    user_lnk_up  = 1'b1;
    m_rq_tready  = 4'hF;
    set_src(0, 1'b0, 0, 0, 1'b0);
    set_src(1, 1'b0, 0, 0, 1'b0);
    fork
      monitor();
    join_none

    repeat (3) @(posedge user_clk);
    #1;
    check_output("rst_m_tvalid", 256'(m_rq_tvalid), 256'(0));
    check_output("rst_m_beat", 256'({m_rq_tdata, m_rq_tuser, m_rq_tkeep, m_rq_tlast}), 256'(0));
    check_output("rst_readies", 256'({s0_rq_tready, s1_rq_tready}), 256'(0));
    check_output("rst_counts", 256'({pkt_cnt0, pkt_cnt1}), 256'(0));
    user_reset_n = 1'b1;
    @(posedge user_clk);
    #1;

    $display("[TB] single source 3-beat TLP");
    base = out_log.size();
    c0   = cyc;
    apply_stimulus(0, 3, 32'h0000_00A1, 0);
    wait_drain();
    check_output("single_len", 256'(out_log.size()), 256'(base + 3));
    check_tlp("single", base, 32'h0000_00A1, 3);
    for (int i = 0; i < 3; i++) begin
      check_output("single_cycle", 256'(out_log[base+i].cyc), 256'(c0 + 3 + i));
    end
    check_output("single_cnt0", 256'(pkt_cnt0), 256'(1));

    $display("[TB] contention round robin");
    do_reset();
    base = out_log.size();
    order_tags = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0001, 32'h1000_0001};
    fork
      begin
        apply_stimulus(0, 2, 32'h0000_0000, 0);
        apply_stimulus(0, 2, 32'h0000_0001, 0);
      end
      begin
        apply_stimulus(1, 2, 32'h1000_0000, 0);
        apply_stimulus(1, 2, 32'h1000_0001, 0);
      end
    join
    wait_drain();
    check_output("contend_len", 256'(out_log.size()), 256'(base + 8));
    for (int t = 0; t < 4; t++) begin
      check_tlp("contend", base + 2 * t, order_tags[t], 2);
    end
    check_output("contend_cnt0", 256'(pkt_cnt0), 256'(2));
    check_output("contend_cnt1", 256'(pkt_cnt1), 256'(2));

    $display("[TB] backpressure during 4-beat s1 TLP");
    base = out_log.size();
    m_rq_tready = 4'h0;
    fork
      apply_stimulus(1, 4, 32'h2000_0000, 0);
      begin
        repeat (5) @(negedge user_clk);
        check_output("bp_s1_ready", 256'(s1_rq_tready), 256'(0));
        check_output("bp_m_tvalid", 256'(m_rq_tvalid), 256'(1));
        check_output("bp_head_beat", 256'(m_rq_tdata[127:64]), 256'({32'h2000_0000, 32'd0}));
        @(posedge user_clk);
        #1;
        m_rq_tready = 4'hF;
      end
    join
    wait_drain();
    check_output("bp_len", 256'(out_log.size()), 256'(base + 4));
    check_tlp("bp", base, 32'h2000_0000, 4);

    $display("[TB] link gating");
    base = out_log.size();
    user_lnk_up = 1'b0;
    fork
      apply_stimulus(0, 2, 32'h3000_0000, 0);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge user_clk);
          check_output("lnk_gate_ready", 256'(s0_rq_tready), 256'(0));
        end
        @(posedge user_clk);
        #1;
        user_lnk_up = 1'b1;
      end
    join
    wait_drain();
    check_tlp("lnk_after", base, 32'h3000_0000, 2);
    base = out_log.size();
    fork
      apply_stimulus(0, 4, 32'h3000_0001, 0);
      begin
        int n = 0;
        do begin
          @(negedge user_clk);
          n++;
        end while (!(s0_rq_tvalid && s0_rq_tready) && n < 50);
        @(posedge user_clk);
        #1;
        user_lnk_up = 1'b0;
      end
    join
    wait_drain();
    check_output("lnk_drop_len", 256'(out_log.size()), 256'(base + 4));
    check_tlp("lnk_drop", base, 32'h3000_0001, 4);
    user_lnk_up = 1'b1;

    $display("[TB] randomized traffic, 1000 TLPs");
    do_reset();
    done = 1'b0;
    fork
      begin
        fork
          for (int i = 0; i < 500; i++) apply_stimulus(0, int'($urandom_range(4, 1)), {4'h4, 28'(i)}, 3);
          for (int i = 0; i < 500; i++) apply_stimulus(1, int'($urandom_range(4, 1)), {4'h5, 28'(i)}, 3);
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge user_clk);
          #1;
          m_rq_tready = {3'($urandom()), ($urandom_range(99, 0) < 65)};
        end
      end
    join
    m_rq_tready = 4'hF;
    wait_drain();
    check_output("rand_cnt0", 256'(pkt_cnt0), 256'(500));
    check_output("rand_cnt1", 256'(pkt_cnt1), 256'(500));

    $display("[TB] counter wrap");
    preload0 = 1'b1;
    force dut.cnt0_q = 16'hFFFF;
    @(posedge user_clk);
    #1;
    release dut.cnt0_q;
    preload0 = 1'b0;
    @(posedge user_clk);
    #1;
    check_output("wrap_preload", 256'(pkt_cnt0), 256'(16'hFFFF));
    base = out_log.size();
    apply_stimulus(0, 1, 32'h6000_00FF, 0);
    wait_drain();
    check_tlp("wrap_tlp", base, 32'h6000_00FF, 1);
    check_output("wrap_cnt0", 256'(pkt_cnt0), 256'(0));

    $display("[TB] reset mid-packet");
    m_rq_tready = 4'h0;
    set_src(1, 1'b1, 32'h7000_0000, 0, 1'b0);
    repeat (4) @(posedge user_clk);
    #3;
    user_reset_n = 1'b0;
    #1;
    check_output("mid_rst_m_tvalid", 256'(m_rq_tvalid), 256'(0));
    check_output("mid_rst_m_beat", 256'({m_rq_tdata, m_rq_tuser, m_rq_tkeep, m_rq_tlast}), 256'(0));
    check_output("mid_rst_readies", 256'({s0_rq_tready, s1_rq_tready}), 256'(0));
    check_output("mid_rst_counts", 256'({pkt_cnt0, pkt_cnt1}), 256'(0));
    set_src(1, 1'b0, 0, 0, 1'b0);
    @(posedge user_clk);
    #1;
    user_reset_n = 1'b1;
    m_rq_tready  = 4'hF;
    @(posedge user_clk);
    #1;
    base = out_log.size();
    fork
      apply_stimulus(0, 2, 32'h8000_0000, 0);
      apply_stimulus(1, 3, 32'h9000_0000, 0);
    join
    wait_drain();
    check_output("post_rst_len", 256'(out_log.size()), 256'(base + 5));
    check_tlp("post_rst_s0", base, 32'h8000_0000, 2);
    check_tlp("post_rst_s1", base + 2, 32'h9000_0000, 3);
    check_output("post_rst_cnt1", 256'(pkt_cnt1), 256'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
